video_timing: RTL
=================

# video_timing

Video timing generator that produces the raster coordinates (`spotX`, `spotY`) and sync/blank signals consumed by the pixel-colour stages (background, sprites, tiles). It sits at the head of the display pipeline and drives the SVGA 800x600@72 Hz output from a 50 MHz pixel clock. Coordinates are signed: blanking positions are negative and the active area is 0..HACTIVE-1 / 0..VACTIVE-1, so downstream stages test `spotX < HACTIVE` and `spotX >= 0` directly.

## Interface
- HACTIVE, 800, active pixels per line
- HFP, 56, horizontal front porch (pixels)
- HSYNC, 120, horizontal sync width
- HBP, 64, horizontal back porch
- VACTIVE, 600, active lines per frame
- VFP, 37, vertical front porch (lines)
- VSYNC, 6, vertical sync width
- VBP, 23, vertical back porch
- HS_POL, 1, hsync polarity (1 = active-high)
- VS_POL, 1, vsync polarity

- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel advance enable; counters hold when 0
- spotX  out  11 signed  horizontal coordinate, -(HFP+HSYNC+HBP)..HACTIVE-1
- spotY  out  11 signed  vertical coordinate, -(VFP+VSYNC+VBP)..VACTIVE-1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- blank  out  1  high whenever spotX<0 or spotY<0
- frame_start  out  1  one-cycle pulse on first pixel of a frame
- vblank_start  out  1  one-cycle pulse when spotY leaves active area

## Operation
- Line order: front porch, sync, back porch, active. Horizontal counter h_cnt 0..HTOTAL-1 (HTOTAL=1040); spotX = h_cnt - HBLANK (HBLANK=240).
- Horizontal phases (defaults): FRONT spotX -240..-185, SYNC -184..-65, BACK -64..-1, ACTIVE 0..799.
- Vertical counter v_cnt 0..VTOTAL-1 (VTOTAL=666); spotY = v_cnt - VBLANK (VBLANK=66). FRONT -66..-30, SYNC -29..-24, BACK -23..-1, ACTIVE 0..599.
- Each axis runs a 4-state FSM FRONT->SYNC->BACK->ACTIVE->FRONT; transition when the axis counter reaches the phase end and the axis advances. Horizontal advances on every cycle with pix_en=1; vertical advances only when horizontal wraps (ACTIVE last pixel -> FRONT).
- Wrap: spotX 799 -> -240 and spotY increments in the same cycle; spotY 599 -> -66 on the horizontal wrap of the last line.
- hsync = HS_POL when h-state SYNC, else !HS_POL. vsync = VS_POL for whole lines in v-state SYNC (changes with spotX wrap).
- frame_start high for one enabled cycle when spotX=-240 and spotY=-66 after a wrap (not after reset). vblank_start high for the cycle where spotY becomes -66.
- pix_en=0: all outputs hold, pulses forced 0.
- Arithmetic: counters unsigned 11 bit; coordinate subtraction in signed 12 bit, truncated to 11 (ranges fit).
- Parameter legality: each porch/sync >=1, HTOTAL and VTOTAL <= 1024 + HACTIVE constraints checked by elaboration assertion (totals < 2048, blank < 1024).

## Timing
- All outputs registered; spotX, spotY, hsync, vsync, blank, pulses describe the same pixel in the same cycle.
- Reset values: spotX=-240, spotY=-66, hsync=!HS_POL, vsync=!VS_POL, blank=1, frame_start=0, vblank_start=0, both FSMs FRONT.
- Reset asserted mid-line: outputs take reset values immediately (asynchronous); first advance after release gives spotX=-239.
- Line period HTOTAL enabled cycles; frame period HTOTAL*VTOTAL = 692640 enabled cycles.

## Structure
- Package video_pkg: phase enum (FRONT, SYNC, BACK, ACTIVE), default SVGA timing constants, derived HBLANK/HTOTAL/VBLANK/VTOTAL functions.
- Sub-module sync_axis: counter + phase FSM + sync bit for one axis, inputs advance, outputs count, phase, wrap; instantiated twice (horizontal advance=pix_en, vertical advance=pix_en & h wrap).

## Test plan
- Reset: hold rst, check spotX=-240, spotY=-66, blank=1, sync inactive; release, 240 cycles -> spotX=0, blank=0 only once spotY>=0.
- Line: measure hsync active exactly 120 cycles starting at spotX=-184; period 1040 cycles; spotX 799 -> -240 with spotY+1 same cycle.
- Frame: vsync active exactly 6*1040 cycles from spotY=-29; vblank_start at spotY 599 -> -66; frame_start every 692640 cycles.
- pix_en toggled randomly 50%: outputs hold on disabled cycles, pulses never high with pix_en=0, line length = 1040 enabled cycles.
- Reset mid-frame at spotX=400, spotY=300: immediate return to reset values, no frame_start on release.
- Non-default params (HACTIVE=640, HFP=16, HSYNC=96, HBP=48, HS_POL=0): spotX range -160..639, hsync low for 96 cycles.

Source files
------------

// File: rtl/video_pkg.sv
// Shared phase encoding and default SVGA 800x600@72 timing for the video timing generator.
package video_pkg;

  typedef enum logic [1:0] {PhFront, PhSync, PhBack, PhActive} phase_e;

  localparam int unsigned CoordW = 11;

  localparam int unsigned DefHActive = 800;
  localparam int unsigned DefHFp     = 56;
  localparam int unsigned DefHSync   = 120;
  localparam int unsigned DefHBp     = 64;
  localparam int unsigned DefVActive = 600;
  localparam int unsigned DefVFp     = 37;
  localparam int unsigned DefVSync   = 6;
  localparam int unsigned DefVBp     = 23;

  function automatic int unsigned blank_len(input int unsigned fp, input int unsigned sync_w,
                                            input int unsigned bp);
    return fp + sync_w + bp;
  endfunction

  function automatic int unsigned total_len(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync_w, input int unsigned bp);
    return active + blank_len(fp, sync_w, bp);
  endfunction

endpackage

// File: rtl/video_timing_sync_axis.sv
// One raster axis: position counter, FRONT->SYNC->BACK->ACTIVE phase FSM, signed coordinate
// and sync bit, all registered so they describe the same position.
module sync_axis
  import video_pkg::*;
#(
  parameter int unsigned Active = DefHActive,
  parameter int unsigned Fp     = DefHFp,
  parameter int unsigned SyncW  = DefHSync,
  parameter int unsigned Bp     = DefHBp,
  parameter bit          Pol    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
  output logic [CoordW-1:0] count_o,
  output logic [CoordW-1:0] coord_o,
  output logic [1:0]        phase_o,
  output logic              sync_o,
  output logic              wrap_o,
  output logic              in_active_o
);

  localparam int unsigned Blank       = blank_len(Fp, SyncW, Bp);
  localparam int unsigned Total       = total_len(Active, Fp, SyncW, Bp);
  localparam int unsigned FrontEndInt = Fp - 1;
  localparam int unsigned SyncEndInt  = Fp + SyncW - 1;
  localparam int unsigned BackEndInt  = Blank - 1;
  localparam int unsigned LastInt     = Total - 1;
  localparam int unsigned CoordRstInt = (1 << CoordW) - Blank;

  localparam logic [CoordW-1:0] FrontEnd  = FrontEndInt[CoordW-1:0];
  localparam logic [CoordW-1:0] SyncEnd   = SyncEndInt[CoordW-1:0];
  localparam logic [CoordW-1:0] BackEnd   = BackEndInt[CoordW-1:0];
  localparam logic [CoordW-1:0] LastCnt   = LastInt[CoordW-1:0];
  localparam logic [CoordW-1:0] CoordRst  = CoordRstInt[CoordW-1:0];
  localparam logic [CoordW:0]   BlankWide = Blank[CoordW:0];

  // The signed coordinate range only fits 11 bits when blanking stays below 1024.
  if (Active < 1 || Active > 1024 || Fp < 1 || SyncW < 1 || Bp < 1 || Blank >= 1024)
  begin : g_bad_params
    $error("sync_axis: illegal timing parameters");
  end

  phase_e            phase_q, phase_d;
  logic [CoordW-1:0] count_q, count_d;
  logic [CoordW-1:0] coord_q, coord_d;
  logic              sync_q, sync_d;
  logic              at_last;
  logic [CoordW:0]   coord_wide;

  assign at_last = (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
      unique case (phase_q)
        PhFront:  if (count_q == FrontEnd) phase_d = PhSync;
        PhSync:   if (count_q == SyncEnd)  phase_d = PhBack;
        PhBack:   if (count_q == BackEnd)  phase_d = PhActive;
        PhActive: if (at_last)             phase_d = PhFront;
        default:  phase_d = PhFront;
      endcase
    end
  end

  assign coord_wide = {1'b0, count_d} - BlankWide;
  assign coord_d    = coord_wide[CoordW-1:0];
  assign sync_d     = (phase_d == PhSync) ? Pol : !Pol;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      phase_q <= PhFront;
      coord_q <= CoordRst;
      sync_q  <= !Pol;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      coord_q <= coord_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o     = count_q;
  assign coord_o     = coord_q;
  assign phase_o     = phase_q;
  assign sync_o      = sync_q;
  assign wrap_o      = advance_i & at_last;
  assign in_active_o = (phase_d == PhActive);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: signed spot coordinates, sync, blank and frame pulses for the
// pixel-colour pipeline. Vertical axis steps once per horizontal wrap.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned HACTIVE = DefHActive,
  parameter int unsigned HFP     = DefHFp,
  parameter int unsigned HSYNC   = DefHSync,
  parameter int unsigned HBP     = DefHBp,
  parameter int unsigned VACTIVE = DefVActive,
  parameter int unsigned VFP     = DefVFp,
  parameter int unsigned VSYNC   = DefVSync,
  parameter int unsigned VBP     = DefVBp,
  parameter bit          HS_POL  = 1'b1,
  parameter bit          VS_POL  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_en,
  output logic signed [CoordW-1:0] spotX,
  output logic signed [CoordW-1:0] spotY,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     blank,
  output logic                     frame_start,
  output logic                     vblank_start
);

  localparam int unsigned HBlankInt = blank_len(HFP, HSYNC, HBP);
  localparam int unsigned VBlankInt = blank_len(VFP, VSYNC, VBP);
  localparam logic [CoordW-1:0] HBlank = HBlankInt[CoordW-1:0];
  localparam logic [CoordW-1:0] VBlank = VBlankInt[CoordW-1:0];

  logic [CoordW-1:0] h_count, v_count, h_coord, v_coord;
  logic [1:0]        h_phase, v_phase;
  logic              h_wrap, v_wrap, h_act_d, v_act_d;

  sync_axis #(
    .Active(HACTIVE),
    .Fp    (HFP),
    .SyncW (HSYNC),
    .Bp    (HBP),
    .Pol   (HS_POL)
  ) u_h_axis (
    .clk_i      (clk),
    .rst_i      (rst),
    .advance_i  (pix_en),
    .count_o    (h_count),
    .coord_o    (h_coord),
    .phase_o    (h_phase),
    .sync_o     (hsync),
    .wrap_o     (h_wrap),
    .in_active_o(h_act_d)
  );

  sync_axis #(
    .Active(VACTIVE),
    .Fp    (VFP),
    .SyncW (VSYNC),
    .Bp    (VBP),
    .Pol   (VS_POL)
  ) u_v_axis (
    .clk_i      (clk),
    .rst_i      (rst),
    .advance_i  (h_wrap),
    .count_o    (v_count),
    .coord_o    (v_coord),
    .phase_o    (v_phase),
    .sync_o     (vsync),
    .wrap_o     (v_wrap),
    .in_active_o(v_act_d)
  );

  logic blank_q, blank_d, frame_start_q, vblank_start_q, pulse_d;

  // Lines open with the front porch, so the frame start and the drop out of the active
  // area are the same event: the vertical wrap.
  assign pulse_d = v_wrap;
  assign blank_d = !(h_act_d && v_act_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q        <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      blank_q        <= blank_d;
      frame_start_q  <= pulse_d;
      vblank_start_q <= pulse_d;
    end
  end

  assign spotX        = h_coord;
  assign spotY        = v_coord;
  assign blank        = blank_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

  // Coordinates, counters and phases are separate registers; they must stay in lockstep.
  assert property (@(posedge clk) disable iff (rst)
    ((h_count - HBlank) == h_coord) && ((h_phase == PhActive) == !h_coord[CoordW-1]));
  assert property (@(posedge clk) disable iff (rst)
    ((v_count - VBlank) == v_coord) && ((v_phase == PhActive) == !v_coord[CoordW-1]));

endmodule
